scs8hd_o2111a_pipe: RTL and testbench

SCS8HD_O2111A_PIPE -- requirements
Module: scs8hd_o2111a_pipe

---
 rtl/scs8hd_o2111a_pipe.sv | 99 +++++++++
 tb/tb_scs8hd_o2111a_pipe.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/scs8hd_o2111a_pipe.sv
// Pipelined o2111a lane array: X=(A1|A2)&B1&C1&D1 per lane (inverted when MODE=1) feeding a DEPTH-entry result FIFO.
// Optional saturating hit counter on nonzero pops is enabled by defining SC_O2111A_HITCNT_EN.
module scs8hd_o2111a_pipe #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2,
  parameter int MODE  = 0,
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RESET_B,
  input  logic [WIDTH-1:0] A1,
  input  logic [WIDTH-1:0] A2,
  input  logic [WIDTH-1:0] B1,
  input  logic [WIDTH-1:0] C1,
  input  logic [WIDTH-1:0] D1,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] X,
  output logic             out_valid,
  input  logic             out_ready
`ifdef SC_O2111A_HITCNT_EN
  ,
  input  logic             hit_clr,
  output logic [CNT_W-1:0] hit_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH + 1);

  if (WIDTH < 1 || WIDTH > 32 || DEPTH < 2 || DEPTH > 16 ||
      (MODE != 0 && MODE != 1) || CNT_W < 2 || CNT_W > 16) begin : g_bad_params
    $error("scs8hd_o2111a_pipe: parameter out of range");
  end

  // Handshake: a transfer happens on a rising CLK edge when valid and ready are
  // both high; ready never depends combinationally on the partner's valid/ready.
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [OW-1:0]    occ;
  logic             started;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] lane_or;
  logic [WIDTH-1:0] result;

  assign lane_or   = (A1 | A2) & B1 & C1 & D1;
  assign result    = (MODE != 0) ? ~lane_or : lane_or;

  // in_ready stays low until the first edge after reset release.
  assign in_ready  = started && (occ != OW'(DEPTH));
  assign out_valid = (occ != '0);
  assign X         = out_valid ? mem[rd_ptr] : '0;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= result;
    end
  end

  always_ff @(posedge CLK or negedge RESET_B) begin
    if (!RESET_B) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      occ     <= '0;
      started <= 1'b0;
    end else begin
      started <= 1'b1;
      if (push) begin
        wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

`ifdef SC_O2111A_HITCNT_EN
  always_ff @(posedge CLK or negedge RESET_B) begin
    if (!RESET_B) begin
      hit_cnt <= '0;
    end else if (hit_clr) begin
      hit_cnt <= '0;
    end else if (pop && (|X) && (hit_cnt != '1)) begin
      hit_cnt <= hit_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_scs8hd_o2111a_pipe.sv
// Bench for scs8hd_o2111a_pipe: two instances (DEPTH=2/MODE=0 and DEPTH=3/MODE=1) share stimulus;
// a queue model is compared every cycle, plus hand-computed literal checks.
module tb_scs8hd_o2111a_pipe;

  logic       CLK = 1'b0;
  logic       RESET_B = 1'b0;
  logic [3:0] A1 = '0, A2 = '0, B1 = '0, C1 = '0, D1 = '0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic       hit_clr = 1'b0;

  logic       in_ready0, out_valid0, in_ready1, out_valid1;
  logic [3:0] x0, x1;
`ifdef SC_O2111A_HITCNT_EN
  logic [1:0] hit_cnt0, hit_cnt1;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- clock ----------------
  always #5 CLK = ~CLK;

  // ---------------- DUTs ----------------
  scs8hd_o2111a_pipe #(.WIDTH(4), .DEPTH(2), .MODE(0), .CNT_W(2)) u0 (
    .CLK(CLK), .RESET_B(RESET_B), .A1(A1), .A2(A2), .B1(B1), .C1(C1), .D1(D1),
    .in_valid(in_valid), .in_ready(in_ready0), .X(x0), .out_valid(out_valid0),
    .out_ready(out_ready)
`ifdef SC_O2111A_HITCNT_EN
    , .hit_clr(hit_clr), .hit_cnt(hit_cnt0)
`endif
  );

  scs8hd_o2111a_pipe #(.WIDTH(4), .DEPTH(3), .MODE(1), .CNT_W(2)) u1 (
    .CLK(CLK), .RESET_B(RESET_B), .A1(A1), .A2(A2), .B1(B1), .C1(C1), .D1(D1),
    .in_valid(in_valid), .in_ready(in_ready1), .X(x1), .out_valid(out_valid1),
    .out_ready(out_ready)
`ifdef SC_O2111A_HITCNT_EN
    , .hit_clr(hit_clr), .hit_cnt(hit_cnt1)
`endif
  );

  // ---------------- model ----------------
  logic [3:0] exp_q0[$];
  logic [3:0] exp_q1[$];
  bit         m_started = 0;
  int         m_cnt0 = 0;
  int         m_cnt1 = 0;

  function automatic logic [3:0] lane_fn(input logic [3:0] a1, a2, b1, c1, d1, input bit inv);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) begin
      r[i] = (a1[i] || a2[i]) && b1[i] && c1[i] && d1[i];
      if (inv) r[i] = !r[i];
    end
    return r;
  endfunction

  function automatic int sat_inc(input int v);
    return (v >= 3) ? 3 : v + 1;
  endfunction

  always @(posedge CLK or negedge RESET_B) begin
    if (!RESET_B) begin
      exp_q0.delete();
      exp_q1.delete();
      m_started = 0;
      m_cnt0 = 0;
      m_cnt1 = 0;
    end else begin
      bit push0, push1, pop0, pop1;
      logic [3:0] h0, h1;
      push0 = in_valid && m_started && (exp_q0.size() < 2);
      push1 = in_valid && m_started && (exp_q1.size() < 3);
      pop0  = out_ready && (exp_q0.size() > 0);
      pop1  = out_ready && (exp_q1.size() > 0);
      h0 = pop0 ? exp_q0.pop_front() : 4'h0;
      h1 = pop1 ? exp_q1.pop_front() : 4'h0;
      if (push0) exp_q0.push_back(lane_fn(A1, A2, B1, C1, D1, 1'b0));
      if (push1) exp_q1.push_back(lane_fn(A1, A2, B1, C1, D1, 1'b1));
      if (hit_clr) begin
        m_cnt0 = 0;
        m_cnt1 = 0;
      end else begin
        if (pop0 && h0 != 0) m_cnt0 = sat_inc(m_cnt0);
        if (pop1 && h1 != 0) m_cnt1 = sat_inc(m_cnt1);
      end
      m_started = 1;
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    check("u0_in_ready", 32'(in_ready0), 32'(m_started && exp_q0.size() < 2));
    check("u0_out_valid", 32'(out_valid0), 32'(exp_q0.size() > 0));
    if (exp_q0.size() > 0) check("u0_x", 32'(x0), 32'(exp_q0[0]));
    check("u1_in_ready", 32'(in_ready1), 32'(m_started && exp_q1.size() < 3));
    check("u1_out_valid", 32'(out_valid1), 32'(exp_q1.size() > 0));
    if (exp_q1.size() > 0) check("u1_x", 32'(x1), 32'(exp_q1[0]));
`ifdef SC_O2111A_HITCNT_EN
    check("u0_hit_cnt", 32'(hit_cnt0), 32'(m_cnt0));
    check("u1_hit_cnt", 32'(hit_cnt1), 32'(m_cnt1));
`endif
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic set_ops(input logic [3:0] a1, a2, b1, c1, d1);
    A1 = a1; A2 = a2; B1 = b1; C1 = c1; D1 = d1;
  endtask

  logic [3:0] tab_a1[4], tab_a2[4], tab_b1[4], tab_c1[4], tab_d1[4], tab_x[4];
  int pops1;

  initial begin
    tab_a1 = '{4'hF, 4'h0, 4'hC, 4'hF};
    tab_a2 = '{4'h0, 4'h0, 4'h3, 4'h0};
    tab_b1 = '{4'hF, 4'hF, 4'hA, 4'hF};
    tab_c1 = '{4'hF, 4'hF, 4'hF, 4'h5};
    tab_d1 = '{4'h7, 4'hF, 4'hF, 4'hF};
    tab_x  = '{4'h7, 4'h0, 4'hA, 4'h5};

    // reset state
    repeat (2) tick();
    check("rst_out_valid", 32'(out_valid0), 32'h0);
    check("rst_in_ready", 32'(in_ready0), 32'h0);
    check("rst_x", 32'(x0), 32'h0);
    RESET_B = 1'b1;
    tick();
    check("release_in_ready", 32'(in_ready0), 32'h1);

    // basic lane function, both modes
    set_ops(4'b0001, 4'b0010, 4'b1111, 4'b1111, 4'b1111);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("basic_out_valid", 32'(out_valid0), 32'h1);
    check("basic_x_mode0", 32'(x0), 32'h3);
    check("basic_x_mode1", 32'(x1), 32'hC);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // directed lane table, streaming push+pop
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      set_ops(tab_a1[k], tab_a2[k], tab_b1[k], tab_c1[k], tab_d1[k]);
      tick();
      check("table_x", 32'(x0), 32'(tab_x[k]));
    end
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;

    // full / backpressure
    in_valid = 1'b1;
    set_ops(4'h5, 4'h0, 4'hF, 4'hF, 4'hF);
    tick();
    set_ops(4'h6, 4'h0, 4'hF, 4'hF, 4'hF);
    tick();
    check("full_in_ready", 32'(in_ready0), 32'h0);
    set_ops(4'h9, 4'h0, 4'hF, 4'hF, 4'hF);
    tick();
    in_valid = 1'b0;
    check("full_x_first", 32'(x0), 32'h5);
    check("full_in_ready_hold", 32'(in_ready0), 32'h0);
    check("full_u1_x_first", 32'(x1), 32'hA);
    out_ready = 1'b1;
    tick();
    check("full_x_second", 32'(x0), 32'h6);
    repeat (3) tick();
    out_ready = 1'b0;

    // ordering with simultaneous push and pop at occupancy 1
    in_valid = 1'b1;
    set_ops(4'h1, 4'h0, 4'hF, 4'hF, 4'hF);
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      set_ops(4'(i + 2), 4'(i * 5), 4'(15 - i), 4'hF, 4'(i | 8));
      tick();
      check("occ1_out_valid", 32'(out_valid0), 32'h1);
    end
    in_valid = 1'b0;
    repeat (3) tick();
    out_ready = 1'b0;

    // wrap with interleaved pushes and pops (7 pushes)
    pops1 = 0;
    for (int i = 0; i < 14; i++) begin
      in_valid = (i < 10) && (i % 3 != 2);
      out_ready = (i % 2 == 1) || (i >= 10);
      set_ops(4'(i), 4'h0, 4'hF, 4'hF, 4'hF);
      @(posedge CLK);
      if (out_valid1 && out_ready) pops1++;
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("wrap_pop_count", 32'(pops1), 32'd7);

    // reset mid-operation with occupancy 2
    in_valid = 1'b1;
    set_ops(4'h3, 4'h0, 4'hF, 4'hF, 4'hF);
    repeat (2) tick();
    in_valid = 1'b0;
    #3;
    RESET_B = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid0), 32'h0);
    check("midrst_x", 32'(x0), 32'h0);
    check("midrst_in_ready", 32'(in_ready0), 32'h0);
`ifdef SC_O2111A_HITCNT_EN
    check("midrst_hit_cnt", 32'(hit_cnt0), 32'h0);
`endif
    tick();
    RESET_B = 1'b1;
    tick();
    check("midrst_release_in_ready", 32'(in_ready0), 32'h1);
    check("midrst_release_out_valid", 32'(out_valid0), 32'h0);

    // hit counter saturation and clear priority
    set_ops(4'h3, 4'h0, 4'hF, 4'hF, 4'hF);
    in_valid = 1'b1;
    tick();
    out_ready = 1'b1;
    repeat (4) tick();
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
`ifdef SC_O2111A_HITCNT_EN
    check("hit_cnt_sat", 32'(hit_cnt0), 32'h3);
`endif
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    hit_clr = 1'b1;
    out_ready = 1'b1;
    tick();
    hit_clr = 1'b0;
    out_ready = 1'b0;
`ifdef SC_O2111A_HITCNT_EN
    check("hit_clr_priority", 32'(hit_cnt0), 32'h0);
`endif
    check("final_empty", 32'(out_valid0), 32'h0);
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
